// File: rtl/dmem_responder_if.sv
// Data-memory port bundle between the processor (master) and dmem_responder (slave),
// including the TX byte stream and the timer interrupt line.
interface dmem_responder_if;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  modport master (
    output address_dmem, data, wren, tx_ready,
    input  q_dmem, tx_data, tx_valid, timer_irq
  );

  modport slave (
    input  address_dmem, data, wren, tx_ready,
    output q_dmem, tx_data, tx_valid, timer_irq
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus MMIO (cycle counter, timer compare, status, TX FIFO).
// Define DMEM_RESPONDER_TIMER_IRQ_EN to drive timer_irq from the sticky timer-hit status bit.
module dmem_responder #(
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3
) (
  input logic             clock,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam logic [27:0]      MmioPage  = 28'hFFF_FFFF;
  localparam logic [FIFO_AW:0] FifoFull  = FIFO_DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0] CountOne  = {{FIFO_AW{1'b0}}, 1'b1};

  logic [31:0]        ram [DEPTH];
  logic [7:0]         fifo_mem [FIFO_DEPTH];

  logic [31:0]        q_q, q_d;
  logic [31:0]        cycle_q;
  logic [31:0]        timer_cmp_q, timer_cmp_d;
  logic               hit_q, hit_d;
  logic               ovf_q, ovf_d;
  logic [FIFO_AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;

  logic               is_mmio;
  logic [3:0]         mmio_sel;
  logic [ADDR_W-1:0]  ram_idx;
  logic               ram_we;
  logic               wr_cmp, wr_status, wr_tx;
  logic               fifo_full, fifo_empty;
  logic               pop, push, push_drop;
  logic [31:0]        status_rd;

  assign is_mmio    = bus.address_dmem[31:4] == MmioPage;
  assign mmio_sel   = bus.address_dmem[3:0];
  assign ram_idx    = bus.address_dmem[ADDR_W-1:0];
  assign ram_we     = bus.wren & ~is_mmio;
  assign wr_cmp     = bus.wren & is_mmio & (mmio_sel == 4'h1);
  assign wr_status  = bus.wren & is_mmio & (mmio_sel == 4'h2);
  assign wr_tx      = bus.wren & is_mmio & (mmio_sel == 4'h3);

  assign fifo_full  = count_q == FifoFull;
  assign fifo_empty = count_q == '0;
  assign pop        = bus.tx_valid & bus.tx_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push       = wr_tx & (~fifo_full | pop);
  assign push_drop  = wr_tx & fifo_full & ~pop;

  assign status_rd  = {28'h0, ovf_q, fifo_empty, fifo_full, hit_q};

  always_comb begin
    q_d = '0;
    if (is_mmio) begin
      case (mmio_sel)
        4'h0:    q_d = cycle_q;
        4'h1:    q_d = timer_cmp_q;
        4'h2:    q_d = status_rd;
        default: q_d = '0;
      endcase
    end else if (bus.wren) begin
      q_d = bus.data;
    end else begin
      q_d = ram[ram_idx];
    end
  end

  // Sticky bits: a same-edge set beats a write-1-to-clear.
  always_comb begin
    hit_d = hit_q;
    ovf_d = ovf_q;
    if (wr_status && bus.data[0]) hit_d = 1'b0;
    if (wr_status && bus.data[3]) ovf_d = 1'b0;
    if (cycle_q == timer_cmp_q)   hit_d = 1'b1;
    if (push_drop)                ovf_d = 1'b1;
  end

  always_comb begin
    timer_cmp_d = wr_cmp ? bus.data : timer_cmp_q;
    count_d     = count_q;
    if (push && !pop)      count_d = count_q + CountOne;
    else if (pop && !push) count_d = count_q - CountOne;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q         <= '0;
      cycle_q     <= '0;
      timer_cmp_q <= 32'hFFFF_FFFF;
      hit_q       <= 1'b0;
      ovf_q       <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      q_q         <= q_d;
      cycle_q     <= cycle_q + 32'd1;
      timer_cmp_q <= timer_cmp_d;
      hit_q       <= hit_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end

  // Storage arrays carry no reset; RAM contents survive a reset.
  always_ff @(posedge clock) begin
    if (ram_we) ram[ram_idx] <= bus.data;
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.data[7:0];
  end

  assign bus.q_dmem   = q_q;
  assign bus.tx_valid = ~fifo_empty;
  assign bus.tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];

`ifdef DMEM_RESPONDER_TIMER_IRQ_EN
  assign bus.timer_irq = hit_q;
`else
  assign bus.timer_irq = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a transaction-level model predicts each load result,
// tx_valid and the emitted byte order; monitors compare independently of the stimulus.
module tb_dmem_responder;

  localparam logic [31:0] ACycle  = 32'hFFFF_FFF0;
  localparam logic [31:0] ACmp    = 32'hFFFF_FFF1;
  localparam logic [31:0] AStatus = 32'hFFFF_FFF2;
  localparam logic [31:0] ATx     = 32'hFFFF_FFF3;
  localparam logic [31:0] AIdle   = 32'hFFFF_FFF4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dmem_responder_if bus ();

  dmem_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] q;
    bit          chk_q;
    bit          valid;
    bit          irq;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  exp_tx[$];

  // Reference state
  int unsigned m_cyc;
  int unsigned m_cmp;
  bit          m_hit, m_ovf;
  logic [7:0]  m_fifo[$];
  logic [31:0] m_ram[int];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_cyc = 0;
    m_cmp = 32'hFFFF_FFFF;
    m_hit = 0;
    m_ovf = 0;
    m_fifo.delete();
    exp_tx.delete();
  endfunction

  // One processor transaction, applied at the next rising edge.
  task automatic step(input logic [31:0] addr, input logic [31:0] d, input bit we,
                      input bit rdy);
    int          sz;
    bit          full, empty, pop, mmio, hit_n, ovf_n;
    logic [3:0]  sel;
    exp_t        e;
    @(negedge clock);
    reset = 1'b1;
    bus.address_dmem = addr;
    bus.data         = d;
    bus.wren         = we;
    bus.tx_ready     = rdy;

    sz    = m_fifo.size();
    full  = (sz == 8);
    empty = (sz == 0);
    pop   = !empty && rdy;
    mmio  = (addr[31:4] == 28'hFFF_FFFF);
    sel   = addr[3:0];
    e.q     = '0;
    e.chk_q = 1;
    if (mmio) begin
      if (sel == 0)      e.q = m_cyc;
      else if (sel == 1) e.q = m_cmp;
      else if (sel == 2) e.q = {28'd0, m_ovf, empty, full, m_hit};
    end else if (we) begin
      m_ram[int'(addr % 4096)] = d;
      e.q = d;
    end else if (m_ram.exists(int'(addr % 4096))) begin
      e.q = m_ram[int'(addr % 4096)];
    end else begin
      e.chk_q = 0;
    end

    hit_n = m_hit;
    ovf_n = m_ovf;
    if (we && mmio && sel == 2 && d[0]) hit_n = 0;
    if (we && mmio && sel == 2 && d[3]) ovf_n = 0;
    if (m_cyc == m_cmp) hit_n = 1;
    if (we && mmio && sel == 3 && full && !pop) ovf_n = 1;
    if (we && mmio && sel == 1) m_cmp = d;
    if (pop) exp_tx.push_back(m_fifo.pop_front());
    if (we && mmio && sel == 3 && (!full || pop)) m_fifo.push_back(d[7:0]);
    m_cyc++;
    m_hit = hit_n;
    m_ovf = ovf_n;

    e.valid = (m_fifo.size() != 0);
`ifdef DMEM_RESPONDER_TIMER_IRQ_EN
    e.irq = m_hit;
`else
    e.irq = 0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(AIdle, 32'h0, 1'b0, rdy);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    bus.address_dmem = AIdle;
    bus.data         = '0;
    bus.wren         = 1'b0;
    bus.tx_ready     = 1'b0;
    model_reset();
    #1;
    check("reset_q_dmem", bus.q_dmem, 32'h0);
    check("reset_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("reset_tx_data", {24'h0, bus.tx_data}, 32'h0);
    check("reset_timer_irq", {31'h0, bus.timer_irq}, 32'h0);
    @(negedge clock);
  endtask

  // Per-edge monitor: load data, tx_valid, timer_irq.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_q) check("q_dmem", bus.q_dmem, e.q);
        check("tx_valid", {31'h0, bus.tx_valid}, {31'h0, e.valid});
        check("timer_irq", {31'h0, bus.timer_irq}, {31'h0, e.irq});
      end
    end
  end

  // Stream monitor: each accepted byte must be the next one the model emitted.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clock);
      #2;
      if (reset && bus.tx_valid && bus.tx_ready) begin
        if (exp_tx.size() == 0) begin
          check("tx_unexpected_pop", {24'h0, bus.tx_data}, 32'hXXXX_XXXX);
        end else begin
          b = exp_tx.pop_front();
          check("tx_data", {24'h0, bus.tx_data}, {24'h0, b});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          kind;
    bus.address_dmem = AIdle;
    bus.data         = '0;
    bus.wren         = 1'b0;
    bus.tx_ready     = 1'b0;
    model_reset();
    #1;
    apply_reset();

    // Cycle counter after ten edges
    idle(10, 0);
    step(ACycle, 32'h0, 0, 0);

    // RAM init, write-first, read-back and aliasing
    for (int i = 0; i < 16; i++) step(32'(i), $urandom, 1, 0);
    step(32'd5, 32'hDEAD_BEEF, 1, 0);
    step(32'd5, 32'h0, 0, 0);
    step(32'd5 + 32'd4096, 32'h0, 0, 0);
    step(ACycle, 32'h1234_5678, 1, 0);
    step(ACycle, 32'h0, 0, 0);

    // Timer hit, clear, and set-wins conflict
    step(ACmp, m_cyc + 20, 1, 0);
    step(ACmp, 32'h0, 0, 0);
    idle(19, 0);
    step(AStatus, 32'h0, 0, 0);
    step(AStatus, 32'h1, 1, 0);
    step(AStatus, 32'h0, 0, 0);
    step(ACmp, m_cyc + 5, 1, 0);
    idle(4, 0);
    step(AStatus, 32'h1, 1, 0);
    step(AStatus, 32'h0, 0, 0);
    step(AStatus, 32'h1, 1, 0);

    // Fill past full, then drain
    for (int i = 0; i < 9; i++) step(ATx, 32'h41 + 32'(i), 1, 0);
    step(AStatus, 32'h0, 0, 0);
    step(ATx, 32'h0, 0, 0);
    idle(10, 1);
    step(AStatus, 32'h0, 0, 1);
    step(AStatus, 32'hF, 1, 0);

    // Full FIFO with same-edge push and pop
    for (int i = 0; i < 8; i++) step(ATx, 32'h30 + 32'(i), 1, 0);
    step(ATx, 32'h5A, 1, 1);
    step(AStatus, 32'h0, 0, 0);
    idle(10, 1);
    step(AStatus, 32'h0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      kind = $urandom_range(0, 9);
      a = {$urandom_range(0, 32'h000F_FFFF) << 12} | 32'($urandom_range(0, 15));
      if (a[31:4] == 28'hFFF_FFFF) a[31] = 1'b0;
      case (kind)
        0, 1:    step(a, $urandom, 1, $urandom_range(0, 1));
        2, 3:    step(a, 32'h0, 0, $urandom_range(0, 1));
        4:       step(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)), 32'h0, 0,
                      $urandom_range(0, 1));
        5:       step(ACmp, m_cyc + $urandom_range(1, 30), 1, $urandom_range(0, 1));
        6:       step(AStatus, 32'($urandom_range(0, 15)), 1, $urandom_range(0, 1));
        7, 8:    step(ATx, $urandom, 1, $urandom_range(0, 3) == 0);
        default: step(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)), $urandom, 1,
                      $urandom_range(0, 1));
      endcase
    end
    idle(12, 1);
    step(AStatus, 32'h0, 0, 0);

    // Reset with bytes queued; RAM survives
    for (int i = 0; i < 3; i++) step(ATx, 32'h60 + 32'(i), 1, 0);
    step(32'd5, 32'hCAFE_F00D, 1, 0);
    idle(2, 0);
    @(posedge clock);
    #2;
    check("tx_valid_before_reset", {31'h0, bus.tx_valid}, 32'h1);
    apply_reset();
    step(ACycle, 32'h0, 0, 0);
    step(32'd5, 32'h0, 0, 0);
    step(AStatus, 32'h0, 0, 0);
    idle(2, 1);

    @(posedge clock);
    #3;
    check("tx_bytes_outstanding", 32'(exp_tx.size()), 32'h0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
